// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO for the UART TX/RX data path. It provides a fill level,
// programmable almost-full and almost-empty flags, sticky error flags and a synchronous clear.
module fifo_flex #(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_DEPTH = 16,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clr,
  input  logic                           i_en_wr,
  input  logic                           i_en_rd,
  input  logic [SIZE_DATA-1:0]           i_data,
  output logic [SIZE_DATA-1:0]           o_data,
  output logic                           o_fifo_full,
  output logic                           o_fifo_empty,
  output logic                           o_almost_full,
  output logic                           o_almost_empty,
  output logic [$clog2(SIZE_DEPTH):0]    o_count,
  output logic                           o_overflow,
  output logic                           o_underflow
);

  localparam int SIZE_ADDR = $clog2(SIZE_DEPTH);
  localparam logic [SIZE_ADDR:0]   ZERO_C    = {(SIZE_ADDR+1){1'b0}};
  localparam logic [SIZE_ADDR:0]   ONE_C     = (SIZE_ADDR+1)'(1);
  localparam logic [SIZE_ADDR:0]   DEPTH_C   = (SIZE_ADDR+1)'(SIZE_DEPTH);
  localparam logic [SIZE_ADDR:0]   AFULL_C   = (SIZE_ADDR+1)'(AFULL_TH);
  localparam logic [SIZE_ADDR:0]   AEMPTY_C  = (SIZE_ADDR+1)'(AEMPTY_TH);
  localparam logic [SIZE_ADDR-1:0] PTR_ONE_C = SIZE_ADDR'(1);
  localparam logic [SIZE_ADDR-1:0] PTR_ZERO_C = {SIZE_ADDR{1'b0}};
  localparam logic [SIZE_DATA-1:0] DATA_ZERO_C = {SIZE_DATA{1'b0}};

  logic [SIZE_DATA-1:0] mem_r [SIZE_DEPTH];
  logic [SIZE_ADDR-1:0] wr_ptr_r;
  logic [SIZE_ADDR-1:0] rd_ptr_r;
  logic [SIZE_ADDR:0]   count_r;
  logic [SIZE_ADDR:0]   count_next_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 afull_r;
  logic                 aempty_r;
  logic                 overflow_r;
  logic                 underflow_r;
  logic                 rd_ok_s;
  logic                 wr_ok_s;

  // Accept decisions and next fill level; clear overrides any request.
  always_comb begin
    rd_ok_s      = i_en_rd && !empty_r;
    wr_ok_s      = i_en_wr && (!full_r || rd_ok_s);
    count_next_s = count_r;
    if (i_clr) begin
      count_next_s = ZERO_C;
    end else if (wr_ok_s && !rd_ok_s) begin
      count_next_s = count_r + ONE_C;
    end else if (rd_ok_s && !wr_ok_s) begin
      count_next_s = count_r - ONE_C;
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, fill level and sticky error flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r    <= PTR_ZERO_C;
      rd_ptr_r    <= PTR_ZERO_C;
      count_r     <= ZERO_C;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (i_clr) begin
      wr_ptr_r    <= PTR_ZERO_C;
      rd_ptr_r    <= PTR_ZERO_C;
      count_r     <= ZERO_C;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      if (i_en_wr && !wr_ok_s) begin
        overflow_r <= 1'b1;
      end
      if (i_en_rd && !rd_ok_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Status flags are registered from the next count so they line up with count_r.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_r   <= (ZERO_C == DEPTH_C);
      empty_r  <= 1'b1;
      afull_r  <= (ZERO_C >= AFULL_C);
      aempty_r <= (ZERO_C <= AEMPTY_C);
    end else begin
      full_r   <= (count_next_s == DEPTH_C);
      empty_r  <= (count_next_s == ZERO_C);
      afull_r  <= (count_next_s >= AFULL_C);
      aempty_r <= (count_next_s <= AEMPTY_C);
    end
  end

  // Storage array, not reset; the read path sees pre-write contents on a shared address.
  always_ff @(posedge i_clk) begin
    if (wr_ok_s && !i_clr) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_rd
      logic [SIZE_DATA-1:0] data_r;
      // Registered read: the head word is captured on an accepted read and held otherwise.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          data_r <= DATA_ZERO_C;
        end else if (i_clr) begin
          data_r <= DATA_ZERO_C;
        end else if (rd_ok_s) begin
          data_r <= mem_r[rd_ptr_r];
        end else begin
          data_r <= data_r;
        end
      end
      assign o_data = data_r;
    end else begin : g_fwft
      assign o_data = empty_r ? DATA_ZERO_C : mem_r[rd_ptr_r];
    end
  endgenerate

  assign o_fifo_full    = full_r;
  assign o_fifo_empty   = empty_r;
  assign o_almost_full  = afull_r;
  assign o_almost_empty = aempty_r;
  assign o_count        = count_r;
  assign o_overflow     = overflow_r;
  assign o_underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: a registered-read instance and an FWFT instance
// share the same stimulus and are checked against hand-computed expectations.
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] q0, q1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_flex #(.SIZE_DATA(8), .SIZE_DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_en_wr(wr), .i_en_rd(rd), .i_data(din),
    .o_data(q0), .o_fifo_full(full0), .o_fifo_empty(empty0), .o_almost_full(af0),
    .o_almost_empty(ae0), .o_count(cnt0), .o_overflow(ovf0), .o_underflow(unf0));

  fifo_flex #(.SIZE_DATA(8), .SIZE_DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_en_wr(wr), .i_en_rd(rd), .i_data(din),
    .o_data(q1), .o_fifo_full(full1), .o_fifo_empty(empty1), .o_almost_full(af1),
    .o_almost_empty(ae1), .o_count(cnt1), .o_overflow(ovf1), .o_underflow(unf1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; wr = 1'b0; rd = 1'b0;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    step(); step();
    total++; if (cnt0 !== 5'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty0); end
    total++; if (ae0 !== 1'b1)    begin bad++; $display("FAIL reset_aempty got=%b exp=1", ae0); end
    total++; if (full0 !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b exp=0", full0); end
    total++; if (af0 !== 1'b0)    begin bad++; $display("FAIL reset_afull got=%b exp=0", af0); end
    total++; if (ovf0 !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
    total++; if (unf0 !== 1'b0)   begin bad++; $display("FAIL reset_unf got=%b exp=0", unf0); end
    total++; if (q0 !== 8'h00)    begin bad++; $display("FAIL reset_data0 got=%h exp=00", q0); end
    total++; if (q1 !== 8'h00)    begin bad++; $display("FAIL reset_data1 got=%h exp=00", q1); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; din = 8'(i);
      step();
      total++; if (cnt0 !== 5'(i + 1)) begin bad++; $display("FAIL fill_count0 i=%0d got=%0d exp=%0d", i, cnt0, i + 1); end
      total++; if (cnt1 !== 5'(i + 1)) begin bad++; $display("FAIL fill_count1 i=%0d got=%0d exp=%0d", i, cnt1, i + 1); end
      total++; if (ae0 !== ((i + 1) <= 4)) begin bad++; $display("FAIL fill_aempty i=%0d got=%b", i, ae0); end
      total++; if (af0 !== ((i + 1) >= 12)) begin bad++; $display("FAIL fill_afull i=%0d got=%b", i, af0); end
      total++; if (full0 !== ((i + 1) == 16)) begin bad++; $display("FAIL fill_full i=%0d got=%b", i, full0); end
      total++; if (empty0 !== 1'b0) begin bad++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty0); end
    end
    din = 8'd16;
    step();
    wr = 1'b0;
    total++; if (cnt0 !== 5'd16) begin bad++; $display("FAIL over_count got=%0d exp=16", cnt0); end
    total++; if (ovf0 !== 1'b1)  begin bad++; $display("FAIL over_flag0 got=%b exp=1", ovf0); end
    total++; if (ovf1 !== 1'b1)  begin bad++; $display("FAIL over_flag1 got=%b exp=1", ovf1); end
    total++; if (q1 !== 8'h00)   begin bad++; $display("FAIL over_head1 got=%h exp=00", q1); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      total++; if (q1 !== 8'(i)) begin bad++; $display("FAIL drain_fwft i=%0d got=%h exp=%h", i, q1, 8'(i)); end
      rd = 1'b1;
      step();
      total++; if (q0 !== 8'(i)) begin bad++; $display("FAIL drain_reg i=%0d got=%h exp=%h", i, q0, 8'(i)); end
      total++; if (cnt0 !== 5'(15 - i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, cnt0, 15 - i); end
    end
    step();
    rd = 1'b0;
    total++; if (unf0 !== 1'b1)   begin bad++; $display("FAIL under_flag0 got=%b exp=1", unf0); end
    total++; if (unf1 !== 1'b1)   begin bad++; $display("FAIL under_flag1 got=%b exp=1", unf1); end
    total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL under_empty got=%b exp=1", empty0); end
    total++; if (q0 !== 8'h0f)    begin bad++; $display("FAIL under_hold got=%h exp=0f", q0); end
    total++; if (q1 !== 8'h00)    begin bad++; $display("FAIL under_fwft got=%h exp=00", q1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v;
    pulse_clr();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; din = 8'(i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      exp_v = (i < 16) ? 8'(i) : 8'(8'h40 + i - 16);
      total++; if (q1 !== exp_v) begin bad++; $display("FAIL b2b_fwft i=%0d got=%h exp=%h", i, q1, exp_v); end
      wr = 1'b1; rd = 1'b1; din = 8'(8'h40 + i);
      step();
      total++; if (q0 !== exp_v) begin bad++; $display("FAIL b2b_reg i=%0d got=%h exp=%h", i, q0, exp_v); end
      total++; if (cnt0 !== 5'd16) begin bad++; $display("FAIL b2b_count i=%0d got=%0d exp=16", i, cnt0); end
      total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL b2b_ovf i=%0d got=%b exp=0", i, ovf0); end
    end
    wr = 1'b0; rd = 1'b0;
    step();
    total++; if (full1 !== 1'b1) begin bad++; $display("FAIL b2b_full1 got=%b exp=1", full1); end
    total++; if (q1 !== 8'h44)   begin bad++; $display("FAIL b2b_next got=%h exp=44", q1); end
  endtask

  task automatic test_empty_wr_rd();
    pulse_clr();
    wr = 1'b1; rd = 1'b1; din = 8'ha5;
    step();
    wr = 1'b0; rd = 1'b0;
    total++; if (unf0 !== 1'b1)  begin bad++; $display("FAIL ewr_unf got=%b exp=1", unf0); end
    total++; if (cnt0 !== 5'd1)  begin bad++; $display("FAIL ewr_count got=%0d exp=1", cnt0); end
    total++; if (q1 !== 8'ha5)   begin bad++; $display("FAIL ewr_fwft got=%h exp=a5", q1); end
    total++; if (q0 !== 8'h00)   begin bad++; $display("FAIL ewr_reg got=%h exp=00", q0); end
    rd = 1'b1;
    step();
    rd = 1'b0;
    total++; if (cnt1 !== 5'd0)  begin bad++; $display("FAIL ewr_rd_count got=%0d exp=0", cnt1); end
    total++; if (q1 !== 8'h00)   begin bad++; $display("FAIL ewr_rd_fwft got=%h exp=00", q1); end
    total++; if (q0 !== 8'ha5)   begin bad++; $display("FAIL ewr_rd_reg got=%h exp=a5", q0); end
  endtask

  task automatic test_clear_and_reset();
    pulse_clr();
    rd = 1'b1;
    step();
    rd = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr = 1'b1; din = 8'(8'h10 + i);
      step();
    end
    wr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    total++; if (cnt0 !== 5'd9 || ovf0 !== 1'b1 || unf0 !== 1'b1)
      begin bad++; $display("FAIL clr_setup got=%0d/%b/%b exp=9/1/1", cnt0, ovf0, unf0); end
    clr = 1'b1; wr = 1'b1; din = 8'hee;
    step();
    clr = 1'b0; wr = 1'b0;
    total++; if (cnt0 !== 5'd0)   begin bad++; $display("FAIL clr_count got=%0d exp=0", cnt0); end
    total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL clr_empty got=%b exp=1", empty0); end
    total++; if (ovf0 !== 1'b0)   begin bad++; $display("FAIL clr_ovf got=%b exp=0", ovf0); end
    total++; if (unf0 !== 1'b0)   begin bad++; $display("FAIL clr_unf got=%b exp=0", unf0); end
    total++; if (q0 !== 8'h00)    begin bad++; $display("FAIL clr_data got=%h exp=00", q0); end
    step();
    total++; if (cnt1 !== 5'd0)   begin bad++; $display("FAIL clr_nowrite got=%0d exp=0", cnt1); end
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = 8'(8'h77 + i);
      step();
    end
    rd = 1'b1;
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (cnt0 !== 5'd0 || empty0 !== 1'b1 || ae0 !== 1'b1)
      begin bad++; $display("FAIL arst_status got=%0d/%b/%b exp=0/1/1", cnt0, empty0, ae0); end
    total++; if (q0 !== 8'h00 || q1 !== 8'h00) begin bad++; $display("FAIL arst_data got=%h/%h exp=00/00", q0, q1); end
    total++; if (full0 !== 1'b0 || af0 !== 1'b0 || ovf0 !== 1'b0 || unf0 !== 1'b0)
      begin bad++; $display("FAIL arst_flags got=%b%b%b%b exp=0000", full0, af0, ovf0, unf0); end
    wr = 1'b0; rd = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL arst_after got=%0d exp=0", cnt0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_empty_wr_rd();
    test_clear_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
